// File: rtl/add_accumulator.sv
// Clocked accumulating front end for the 32-bit ripple-carry adder fulladder_32bit.
// Optional feature: define ACC_SATURATE_EN to clamp the accumulator at 32'hFFFF_FFFF on overflow.

module fulladder_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);

    logic [32:0] carry;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < 32; i++) begin : g_bit
            assign S[i]       = A[i] ^ B[i] ^ carry[i];
            assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Cout = carry[32];

endmodule

module add_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_sum,
    output logic             out_carry,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [31:0]      addS;
    logic             addCout;
    logic [31:0]      nextAcc;

    fulladder_32bit u_adder (
        .A    (acc_q),
        .B    (in_data),
        .Cin  (1'b0),
        .S    (addS),
        .Cout (addCout)
    );

`ifdef ACC_SATURATE_EN
    // Any overflow so far in the frame pins the accumulator at all-ones.
    assign nextAcc = (carry_q | addCout) ? 32'hFFFF_FFFF : addS;
`else
    assign nextAcc = addS;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = 32'd0;
                    carry_d = 1'b0;
                    rem_d   = len;
                    state_d = (len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    acc_d   = nextAcc;
                    carry_d = carry_q | addCout;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            carry_q <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
        end
    end

    assign out_sum   = acc_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Self-checking bench for add_accumulator: random frames against a plain-arithmetic frame model.
// Honours ACC_SATURATE_EN the same way the design does.

module tb_add_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int passes = 0;

    logic [31:0] ops[$];
    bit          validPat[$];

    add_accumulator #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        else
            passes++;
    endtask

    // Frame result from unsigned arithmetic: wider sum exposes each wrap directly.
    function automatic void frameModel(input logic [31:0] q[$], output logic [31:0] sum, output logic carry);
        longint unsigned total;
        sum   = 32'd0;
        carry = 1'b0;
        foreach (q[i]) begin
            total = longint'(sum) + longint'(q[i]);
            if (total > 64'hFFFF_FFFF) carry = 1'b1;
`ifdef ACC_SATURATE_EN
            sum = carry ? 32'hFFFF_FFFF : total[31:0];
`else
            sum = total[31:0];
`endif
        end
    endfunction

    // Runs one complete frame from ops[]; validPat (if non-empty) overrides random stalls.
    task automatic applyStimulus(input int n, input int stallPct, input int hold, input bit pulseStart);
        logic [31:0] expSum;
        logic        expCarry;
        int          idx;
        int          cyc;
        int          vi;
        bit          wasReady;

        frameModel(ops, expSum, expCarry);
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        len   = 8'($urandom);
        checkOutput("busy_after_start", busy, 1);
        if (n == 0)
            checkOutput("zero_len_done", out_valid, 1);
        else
            checkOutput("in_ready_acc", in_ready, 1);

        idx = 0;
        cyc = 0;
        vi  = 0;
        while (idx < n && cyc < 2000) begin
            if (validPat.size() > 0) begin
                in_valid = (vi < validPat.size()) ? validPat[vi] : 1'b1;
                vi++;
            end else begin
                in_valid = ($urandom_range(99) >= stallPct);
            end
            in_data = in_valid ? ops[idx] : $urandom;
            if (pulseStart && idx == 1) begin
                start = 1'b1;
                len   = 8'd5;
            end else begin
                start = 1'b0;
            end
            wasReady = in_ready;
            tick();
            if (in_valid && wasReady) idx++;
            if (idx < n) checkOutput("no_early_valid", out_valid, 0);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (idx < n) checkOutput("accept_timeout", 64'(idx), 64'(n));

        checkOutput("out_valid_latency", out_valid, 1);
        checkOutput("in_ready_done", in_ready, 0);
        out_ready = 1'b0;
        repeat (hold) begin
            tick();
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_sum", out_sum, expSum);
        end
        checkOutput("out_sum", out_sum, expSum);
        checkOutput("out_carry", out_carry, expCarry);

        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        checkOutput("idle_after_take", out_valid, 0);
        checkOutput("start_ignored_on_take", busy, 0);
        validPat.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;

        repeat (4) begin
            start     = 1'($urandom);
            len       = 8'($urandom);
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom);
            tick();
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_out_sum", out_sum, 0);
            checkOutput("rst_out_carry", out_carry, 0);
            checkOutput("rst_busy", busy, 0);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        checkOutput("idle_after_reset", busy, 0);

        ops = '{32'd1, 32'd2, 32'd3};
        applyStimulus(3, 0, 0, 1'b0);

        ops = '{32'hFFFF_FFF0, 32'h20};
        applyStimulus(2, 0, 0, 1'b0);

        ops      = '{32'd10, 32'd20, 32'd30, 32'd40};
        validPat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        applyStimulus(4, 0, 5, 1'b0);

        ops.delete();
        applyStimulus(0, 0, 1, 1'b0);

        ops = '{$urandom, $urandom};
        applyStimulus(2, 0, 0, 1'b1);

        // Abort a frame after one operand and confirm nothing leaks into the next.
        start = 1'b1;
        len   = 8'd3;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_out_sum", out_sum, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        ops = '{32'd7};
        applyStimulus(1, 0, 0, 1'b0);

        repeat (8) begin
            int n;
            n = $urandom_range(1, 12);
            ops.delete();
            for (int i = 0; i < n; i++)
                ops.push_back(($urandom_range(1) == 1) ? ($urandom | 32'hC000_0000) : $urandom_range(1000));
            applyStimulus(n, 30, $urandom_range(3), 1'b0);
        end

        ops.delete();
        for (int i = 0; i < 255; i++) ops.push_back($urandom >> 8);
        applyStimulus(255, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
